// File: rtl/hsid_x_obi_burst_reader.sv
// hsid_x_obi_burst_reader
// OBI read master for the HSID-X datapath. A start pulse launches limit_in consecutive
// word reads from initial_addr. Requests are pipelined, and responses are buffered in a
// small FIFO that is drained over a valid/ready stream. The FIFO depth also caps the
// number of reads in flight, so the FIFO cannot overflow.
// Optional feature: define HSID_X_OBI_READER_ERR_EN to add obi_err/error. Erroring
// responses are then dropped, and a sticky error flag is raised.
module hsid_x_obi_burst_reader #(
  parameter int unsigned WORD_WIDTH        = 32,
  parameter int unsigned HSP_LIBRARY_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WORD_WIDTH-1:0]        initial_addr,
  input  logic [HSP_LIBRARY_WIDTH-1:0] limit_in,
  input  logic                         start,
  output logic                         done,
  output logic                         busy,
  output logic                         obi_req,
  input  logic                         obi_gnt,
  output logic [WORD_WIDTH-1:0]        obi_addr,
  output logic                         obi_we,
  output logic [WORD_WIDTH/8-1:0]      obi_be,
  output logic [WORD_WIDTH-1:0]        obi_wdata,
  input  logic                         obi_rvalid,
  input  logic [WORD_WIDTH-1:0]        obi_rdata,
`ifdef HSID_X_OBI_READER_ERR_EN
  input  logic                         obi_err,
  output logic                         error,
`endif
  output logic [WORD_WIDTH-1:0]        data_out,
  output logic                         data_valid,
  input  logic                         data_ready
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [WORD_WIDTH-1:0] ADDR_STEP  = WORD_WIDTH'(WORD_WIDTH / 8);
  localparam logic [WORD_WIDTH-1:0] ALIGN_MASK = ~WORD_WIDTH'(3);
  localparam logic [CNT_W:0]        DEPTH_C    = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Control state
  state_e                       state_q, state_d;
  logic [WORD_WIDTH-1:0]        addr_q, addr_d;
  logic [HSP_LIBRARY_WIDTH-1:0] limit_q, limit_d;
  logic [HSP_LIBRARY_WIDTH-1:0] issued_q, issued_d;
  logic [HSP_LIBRARY_WIDTH-1:0] received_q, received_d;
  logic [CNT_W-1:0]             outst_q, outst_d;
  logic                         req_q, req_d;
  logic                         done_q;
  logic                         busy_q;

  // Response FIFO
  logic [WORD_WIDTH-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]             fifo_cnt_q, fifo_cnt_d;

  // Handshake qualifiers
  logic                         req_fire;
  logic                         rsp_accept;
  logic                         fifo_push;
  logic                         fifo_pop;
  logic [CNT_W:0]               inflight_d;

  // A request completes when the registered request meets a grant
  assign req_fire   = req_q & obi_gnt;
  // Responses count only while reads are in flight.
  // Stale rvalids, for example after a reset, are dropped.
  assign rsp_accept = obi_rvalid & (outst_q != '0);
  assign fifo_pop   = (fifo_cnt_q != '0) & data_ready;

`ifdef HSID_X_OBI_READER_ERR_EN
  logic error_q;

  // An erroring response still counts as received, but its data is discarded
  assign fifo_push = rsp_accept & ~obi_err;

  // Sticky error flag: set by a failed response, cleared by the next accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      error_q <= 1'b0;
    end else if (rsp_accept && obi_err) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  assign fifo_push = rsp_accept;
`endif

  // Next FIFO occupancy; it feeds the issue decision for the coming cycle
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (fifo_push && !fifo_pop) begin
      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    end else if (!fifo_push && fifo_pop) begin
      fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
    end
  end

  // Next-state logic for the sequencer, counters and address
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    limit_d    = limit_q;
    issued_d   = issued_q;
    received_d = received_q;
    outst_d    = outst_q;

    if (req_fire) begin
      issued_d = issued_q + HSP_LIBRARY_WIDTH'(1);
      // Plain modular add: wrapping past the top of the address space is allowed
      addr_d   = addr_q + ADDR_STEP;
    end
    if (rsp_accept) begin
      received_d = received_q + HSP_LIBRARY_WIDTH'(1);
    end
    // A grant and a response in the same cycle cancel out
    if (req_fire && !rsp_accept) begin
      outst_d = outst_q + CNT_W'(1);
    end else if (!req_fire && rsp_accept) begin
      outst_d = outst_q - CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d     = initial_addr & ALIGN_MASK;
          limit_d    = limit_in;
          issued_d   = '0;
          received_d = '0;
          // An empty transfer completes without touching the bus
          state_d    = (limit_in == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (issued_d == limit_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (received_q == limit_q && fifo_cnt_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The request is registered, so the decision uses next-cycle occupancy.
    // Reads in flight plus buffered words never exceed the FIFO depth.
    // Once raised, the request holds until granted: neither the issue count
    // nor that occupancy sum can rise while it waits.
    inflight_d = {1'b0, outst_d} + {1'b0, fifo_cnt_d};
    req_d = (state_d == S_REQ) && (issued_d < limit_d) && (inflight_d < DEPTH_C);
  end

  // Sequencer state and registered bus/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      limit_q    <= '0;
      issued_q   <= '0;
      received_q <= '0;
      outst_q    <= '0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      limit_q    <= limit_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      outst_q    <= outst_d;
      req_q      <= req_d;
      done_q     <= (state_d == S_DONE);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  // FIFO pointers and occupancy. Reset discards any buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // FIFO storage. It has no reset, so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_q] <= obi_rdata;
    end
  end

  assign obi_req    = req_q;
  assign obi_addr   = addr_q;
  assign obi_we     = 1'b0;
  assign obi_be     = '1;
  assign obi_wdata  = '0;
  assign done       = done_q;
  assign busy       = busy_q;
  assign data_valid = (fifo_cnt_q != '0);
  // Mask the head when empty, so unwritten storage never leaks to the stream
  assign data_out   = (fifo_cnt_q != '0) ? fifo_mem[rd_ptr_q] : '0;

endmodule
